imem_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the single-cycle MIPS core's instruction memory. Accepts a byte stream (header + big-endian 32-bit instruction words), assembles words, writes them sequentially into instruction memory from word address 0, then releases the core to run from PC = 0. Replaces bench-only memory preloading, so the same program images (e.g. Factorial) boot in simulation and on hardware.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/imem_word_packer.sv | 54 +++++
 rtl/imem_loader.sv | 170 +++++++++++++++++
 tb/tb_imem_loader.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS boot path: loader FSM states and the
// framing constants of the program image byte stream.
package mips_pkg;

    // Image framing
    localparam int HDR_LEN        = 2;   // count_hi, count_lo
    localparam int BYTES_PER_WORD = 4;   // big-endian instruction bytes
    localparam int INSTR_W        = 32;  // instruction word width

    // Loader FSM states
    typedef enum logic [2:0] {
        LD_HDR_HI = 3'd0,
        LD_HDR_LO = 3'd1,
        LD_WORD   = 3'd2,
        LD_CHK    = 3'd3,
        LD_FINISH = 3'd4,
        LD_DONE   = 3'd5,
        LD_ERROR  = 3'd6
    } loader_state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles a big-endian byte stream into 32-bit instruction words.
// Byte 0 of a word ends up in [31:24], byte 3 in [7:0]. word_valid is a
// one-cycle registered pulse the cycle after the 4th byte is taken, with
// word holding the assembled value from then on.
module imem_word_packer
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               byte_en,
    input  logic [7:0]         byte_data,
    output logic               last_byte,
    output logic               word_valid,
    output logic [INSTR_W-1:0] word
);

    localparam int                IDX_W    = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BYTES_PER_WORD - 1);

    logic [IDX_W-1:0]   idx;
    logic [INSTR_W-9:0] shift;

    // Final byte of the current word is being taken this cycle
    assign last_byte = byte_en && (idx == IDX_LAST);

    // Byte-index counter, shift register and registered word output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            shift      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                idx   <= '0;
                shift <= '0;
                word  <= '0;
            end else if (byte_en) begin
                if (last_byte) begin
                    word       <= {shift, byte_data};
                    word_valid <= 1'b1;
                    idx        <= '0;
                    shift      <= '0;
                end else begin
                    shift <= {shift[INSTR_W-17:0], byte_data};
                    idx   <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader in front of the instruction memory.
// Takes a byte stream (16-bit big-endian word count, then the words MSB
// first), writes words to consecutive addresses from 0, then releases the
// core. Build option: define LOADER_CHECKSUM_EN to expect a trailing XOR
// checksum byte covering every header and word byte.
//
// Handshake: a byte moves only on a cycle where byte_valid && byte_ready;
// byte_ready depends on state only (never on byte_valid), is low in reset
// and low on the cycle restart is high.
module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              restart,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_run,
    output logic              done,
    output logic              error
);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e AFTER_WORDS = LD_CHK;
`else
    localparam loader_state_e AFTER_WORDS = LD_FINISH;
`endif

    loader_state_e       state;
    loader_state_e       next_state;
    logic                accept;
    logic                pack_en;
    logic                last_byte;
    logic                word_valid;
    logic [INSTR_W-1:0]  word;
    logic [7:0]          cnt_hi;
    logic [15:0]         cnt_n;
    logic [ADDR_W:0]     wcnt;      // one extra bit so 2^ADDR_W words fit
    logic [ADDR_W-1:0]   addr_q;
    logic [16:0]         hdr_n;
    logic [16:0]         cap;
    logic                last_word;
    logic                done_d;
    logic                done_q;
    logic                error_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          chk_q;
`endif

    assign hdr_n     = {1'b0, cnt_hi, byte_data};
    assign cap       = 17'd1 << ADDR_W;
    assign last_word = (17'(wcnt) + 17'd1) == {1'b0, cnt_n};
    assign accept    = byte_valid && byte_ready;
    assign pack_en   = accept && (state == LD_WORD);

    // Ready only in byte-consuming states, never in reset or a restart cycle
    always_comb begin
        byte_ready = 1'b0;
        case (state)
            LD_HDR_HI, LD_HDR_LO, LD_WORD, LD_CHK: byte_ready = 1'b1;
            default:                                byte_ready = 1'b0;
        endcase
        if (restart || !rst_n) byte_ready = 1'b0;
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        if (restart) begin
            next_state = LD_HDR_HI;
        end else begin
            case (state)
                LD_HDR_HI: if (accept) next_state = LD_HDR_LO;
                LD_HDR_LO: begin
                    if (accept) begin
                        if (hdr_n > cap)         next_state = LD_ERROR;
                        else if (hdr_n == 17'd0) next_state = AFTER_WORDS;
                        else                     next_state = LD_WORD;
                    end
                end
                LD_WORD:   if (last_byte && last_word) next_state = AFTER_WORDS;
`ifdef LOADER_CHECKSUM_EN
                LD_CHK: begin
                    if (accept) next_state = (byte_data == chk_q) ? LD_FINISH : LD_ERROR;
                end
`endif
                LD_FINISH: next_state = LD_DONE;
                default:   next_state = state;
            endcase
        end
    end

    // done goes high the cycle after the last accepted byte, except after a
    // final word, where it waits one more cycle so it follows that word's write.
    assign done_d = (next_state == LD_DONE) ||
                    ((next_state == LD_FINISH) && (state != LD_WORD));

    // State and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LD_HDR_HI;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state   <= next_state;
            done_q  <= done_d;
            error_q <= (next_state == LD_ERROR);
        end
    end

    // Header capture and word/address counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_hi <= '0;
            cnt_n  <= '0;
            wcnt   <= '0;
            addr_q <= '0;
        end else if (restart) begin
            cnt_hi <= '0;
            cnt_n  <= '0;
            wcnt   <= '0;
            addr_q <= '0;
        end else begin
            if (accept && (state == LD_HDR_HI)) cnt_hi <= byte_data;
            if (accept && (state == LD_HDR_LO)) cnt_n  <= hdr_n[15:0];
            if (last_byte) begin
                addr_q <= wcnt[ADDR_W-1:0];
                wcnt   <= wcnt + (ADDR_W+1)'(1);
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of header and word bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= '0;
        end else if (restart) begin
            chk_q <= '0;
        end else if (accept && (state != LD_CHK)) begin
            chk_q <= chk_q ^ byte_data;
        end
    end
`endif

    imem_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (restart),
        .byte_en    (pack_en),
        .byte_data  (byte_data),
        .last_byte  (last_byte),
        .word_valid (word_valid),
        .word       (word)
    );

    assign im_we    = word_valid;
    assign im_wdata = word;
    assign im_addr  = addr_q;
    assign done     = done_q;
    assign cpu_run  = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: cycle table for the Factorial image, then
// hand-written sequences for empty image, oversize count, gapped stream,
// checksum (when LOADER_CHECKSUM_EN is defined) and reset mid-load.
module tb_imem_loader;

    localparam int ADDR_W = 8;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              restart = 1'b0;
    logic              byte_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_run;
    logic              done;
    logic              error;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .restart    (restart),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .cpu_run    (cpu_run),
        .done       (done),
        .error      (error)
    );

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_miss = 0;
    logic [ADDR_W+31:0] exp_q[$];
    logic [31:0]        img[$];
    int                 we_cyc[$];
    logic               mon_en = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    logic               chk_flip = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every write must match the head of the expected queue
    always @(posedge clk) begin
        #1;
        if (mon_en && im_we) begin
            we_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_write: got addr %0d data %h, required no write", im_addr, im_wdata);
            end else begin
                chk("write", 64'({im_addr, im_wdata}), 64'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = b;
            #1;
            if (byte_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("byte_accept_timeout", 64'(0), 64'(1));
        if (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
    endtask

    task automatic send_image(input bit gap);
        logic [7:0] b[$];
        int n;
        n = img.size();
        b.push_back(8'(n >> 8));
        b.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) b.push_back(img[i][31-8*k -: 8]);
            exp_q.push_back({ADDR_W'(i), img[i]});
        end
`ifdef LOADER_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            foreach (b[j]) x ^= b[j];
            b.push_back(x ^ {7'd0, chk_flip});
        end
`endif
        foreach (b[j]) send_byte(b[j], gap);
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart    = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        #1;
        chk("restart_cycle_ready", 64'(byte_ready), 64'(0));
        @(posedge clk);
        #1;
        restart    = 1'b0;
        byte_valid = 1'b0;
        #1;
        chk("restart_done",  64'(done),       64'(0));
        chk("restart_error", 64'(error),      64'(0));
        chk("restart_run",   64'(cpu_run),    64'(0));
        chk("restart_ready", 64'(byte_ready), 64'(1));
        we_cyc.delete();
    endtask

    task automatic wait_done(output int c);
        c = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done || error) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) chk("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic load_factorial();
        img.delete();
        img.push_back(32'h20080005);
        img.push_back(32'h20090001);
        img.push_back(32'h01000008);
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic              vld;
        logic [7:0]        dat;
        logic              exp_rdy;
        logic              exp_we;
        logic [ADDR_W-1:0] exp_addr;
        logic [31:0]       exp_wdata;
        logic              exp_done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [7:0] d, logic r, logic w,
                                logic [ADDR_W-1:0] a, logic [31:0] wd, logic dn);
        vec_t t;
        t.vld = v; t.dat = d; t.exp_rdy = r; t.exp_we = w;
        t.exp_addr = a; t.exp_wdata = wd; t.exp_done = dn;
        return t;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int c;

        // reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 64'(byte_ready), 64'(0));
        chk("rst_we",    64'(im_we),      64'(0));
        chk("rst_addr",  64'(im_addr),    64'(0));
        chk("rst_wdata", 64'(im_wdata),   64'(0));
        chk("rst_run",   64'(cpu_run),    64'(0));
        chk("rst_done",  64'(done),       64'(0));
        chk("rst_error", 64'(error),      64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(byte_ready), 64'(1));

        // Factorial image, continuous stream, cycle by cycle
        tbl.push_back(mk(1, 8'h00, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h03, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h20, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h08, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h05, 1, 1, 8'd0, 32'h20080005, 0));
        tbl.push_back(mk(1, 8'h20, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h09, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h01, 1, 1, 8'd1, 32'h20090001, 0));
        tbl.push_back(mk(1, 8'h01, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h08, 1, 1, 8'd2, 32'h01000008, 0));
`ifdef LOADER_CHECKSUM_EN
        tbl.push_back(mk(1, 8'h0F, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1));
`else
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1));
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            byte_valid = tbl[i].vld;
            byte_data  = tbl[i].dat;
            #1;
            chk($sformatf("tbl%0d_ready", i), 64'(byte_ready), 64'(tbl[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_we", i), 64'(im_we), 64'(tbl[i].exp_we));
            if (tbl[i].exp_we) begin
                chk($sformatf("tbl%0d_addr", i),  64'(im_addr),  64'(tbl[i].exp_addr));
                chk($sformatf("tbl%0d_wdata", i), 64'(im_wdata), 64'(tbl[i].exp_wdata));
            end
            chk($sformatf("tbl%0d_done", i),  64'(done),    64'(tbl[i].exp_done));
            chk($sformatf("tbl%0d_run", i),   64'(cpu_run), 64'(tbl[i].exp_done));
            chk($sformatf("tbl%0d_error", i), 64'(error),   64'(0));
        end
        byte_valid = 1'b0;
        mon_en = 1'b1;

        // Empty image: done right after the last byte, no writes
        do_restart();
        img.delete();
        send_image(1'b0);
        chk("n0_done", 64'(done),    64'(1));
        chk("n0_run",  64'(cpu_run), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("n0_done_held", 64'(done), 64'(1));
        chk("n0_no_writes", 64'(we_cyc.size()), 64'(0));

        // Oversize count 257 with 256-word memory
        do_restart();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        chk("big_error", 64'(error),      64'(1));
        chk("big_run",   64'(cpu_run),    64'(0));
        chk("big_done",  64'(done),       64'(0));
        chk("big_ready", 64'(byte_ready), 64'(0));
        repeat (5) @(posedge clk);
        #1;
        chk("big_error_held", 64'(error), 64'(1));
        chk("big_no_writes",  64'(we_cyc.size()), 64'(0));

        // Gapped stream: same writes, 8 cycles apart
        do_restart();
        load_factorial();
        send_image(1'b1);
        wait_done(c);
        chk("gap_done",   64'(done), 64'(1));
        chk("gap_nwr",    64'(we_cyc.size()), 64'(3));
        chk("gap_q_empty", 64'(exp_q.size()), 64'(0));
        if (we_cyc.size() == 3) begin
            chk("gap_space01", 64'(we_cyc[1] - we_cyc[0]), 64'(8));
            chk("gap_space12", 64'(we_cyc[2] - we_cyc[1]), 64'(8));
`ifndef LOADER_CHECKSUM_EN
            chk("gap_done_lat", 64'(c - we_cyc[2]), 64'(1));
`endif
        end

`ifdef LOADER_CHECKSUM_EN
        // Checksum good, then bad: word written in both cases
        do_restart();
        img.delete();
        img.push_back(32'h12345678);
        chk_flip = 1'b0;
        send_image(1'b0);
        chk("cks_good_done",  64'(done),  64'(1));
        chk("cks_good_error", 64'(error), 64'(0));
        chk("cks_good_wr",    64'(we_cyc.size()), 64'(1));
        do_restart();
        chk_flip = 1'b1;
        send_image(1'b0);
        chk("cks_bad_error", 64'(error),   64'(1));
        chk("cks_bad_run",   64'(cpu_run), 64'(0));
        chk("cks_bad_wr",    64'(we_cyc.size()), 64'(1));
        chk("cks_bad_q",     64'(exp_q.size()), 64'(0));
        chk_flip = 1'b0;
`endif

        // Reset two bytes into word 0, then a clean full reload
        do_restart();
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h08, 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(byte_ready), 64'(0));
        chk("mid_rst_we",    64'(im_we),      64'(0));
        chk("mid_rst_addr",  64'(im_addr),    64'(0));
        chk("mid_rst_wdata", 64'(im_wdata),   64'(0));
        chk("mid_rst_run",   64'(cpu_run),    64'(0));
        chk("mid_rst_done",  64'(done),       64'(0));
        chk("mid_rst_error", 64'(error),      64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        do_restart();
        load_factorial();
        send_image(1'b0);
        wait_done(c);
        chk("reload_done",  64'(done),    64'(1));
        chk("reload_run",   64'(cpu_run), 64'(1));
        chk("reload_nwr",   64'(we_cyc.size()), 64'(3));
        chk("reload_q",     64'(exp_q.size()), 64'(0));
        if (we_cyc.size() == 3) begin
            chk("reload_space01", 64'(we_cyc[1] - we_cyc[0]), 64'(4));
            chk("reload_space12", 64'(we_cyc[2] - we_cyc[1]), 64'(4));
`ifndef LOADER_CHECKSUM_EN
            chk("reload_done_lat", 64'(c - we_cyc[2]), 64'(1));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule
